// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes
// and the multiply/divide unit state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit (32 CALC cycles + FIX).
// Ports: clk, reset, start, funct3, srca, srcb, rd_in -> busy, done, result, rd_out.
module mdu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  mdu_state_e state, state_n;

  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [4:0]  cnt;
  logic [31:0] m;
  logic [63:0] acc;
  logic        neg;

  logic        go;
  logic        sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        div0, ovf, spec;
  logic [31:0] spec_val;
  logic [32:0] msum, dt, dsub;
  logic [63:0] pfix;
  logic [31:0] dsel, fix_val;

  assign go   = start & (state == S_IDLE | state == S_DONE);
  assign busy = (state == S_CALC) | (state == S_FIX);
  assign done = (state == S_DONE);

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        sa = srca[31];
        sb = srcb[31];
      end
      F3_MULHSU: sa = srca[31];
      default: ;
    endcase
  end

  assign a_mag = sa ? -srca : srca;
  assign b_mag = sb ? -srcb : srcb;

  assign div0 = funct3[2] & (srcb == 32'd0);
  assign ovf  = (funct3 == F3_DIV | funct3 == F3_REM)
              & (srca == 32'h8000_0000)
              & (srcb == 32'hFFFF_FFFF);
  assign spec = div0 | ovf;

  always_comb begin
    spec_val = 32'd0;
    unique case (1'b1)
      div0 & ~funct3[1]: spec_val = 32'hFFFF_FFFF;
      div0 &  funct3[1]: spec_val = srca;
      ovf  & ~funct3[1]: spec_val = 32'h8000_0000;
      default:           spec_val = 32'd0;
    endcase
  end

  // Shift-add: multiplier sits in acc[31:0], partial sum in acc[63:32].
  assign msum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);

  // Restoring divide: remainder in acc[63:32], dividend/quotient in acc[31:0].
  assign dt   = {acc[63:32], acc[31]};
  assign dsub = dt - {1'b0, m};

  assign pfix = neg ? -acc : acc;
  assign dsel = op[1] ? acc[63:32] : acc[31:0];

  always_comb begin
    fix_val = 32'd0;
    if (op[2])
      fix_val = neg ? -dsel : dsel;
    else if (op == F3_MUL)
      fix_val = pfix[31:0];
    else
      fix_val = pfix[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = spec ? S_DONE : S_CALC;
        else       state_n = S_IDLE;
      end
      S_CALC: if (cnt == 5'd31) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= 3'd0;
      rd_q   <= 5'd0;
      cnt    <= 5'd0;
      m      <= 32'd0;
      acc    <= 64'd0;
      neg    <= 1'b0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else if (go) begin
      op   <= funct3;
      rd_q <= rd_in;
      cnt  <= 5'd0;
      // Remainder follows the dividend sign only.
      neg  <= (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
      if (funct3[2]) begin
        m   <= b_mag;
        acc <= {32'd0, a_mag};
      end else begin
        m   <= a_mag;
        acc <= {32'd0, b_mag};
      end
      if (spec) begin
        result <= spec_val;
        rd_out <= rd_in;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 5'd1;
      if (op[2]) begin
        if (!dsub[32]) acc <= {dsub[31:0], acc[30:0], 1'b1};
        else           acc <= {dt[31:0], acc[30:0], 1'b0};
      end else begin
        acc <= {msum, acc[31:1]};
      end
    end else if (state == S_FIX) begin
      result <= fix_val;
      rd_out <= rd_q;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: scoreboard of expected
// writebacks, latency/busy checks, specials, reset abort, back-to-back.
module tb_mdu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } wb_t;

  wb_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .start(start),
    .funct3(funct3), .srca(srca), .srcb(srcb),
    .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  function automatic logic [31:0] ref_mdu(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, p;
    logic [63:0] pu;
    logic signed [31:0] qa, qb, qr;
    xa = $signed({{32{a[31]}}, a});
    xb = $signed({{32{b[31]}}, b});
    qa = $signed(a);
    qb = $signed(b);
    p  = 64'sd0;
    pu = 64'd0;
    qr = 32'sd0;
    case (f3)
      F3_MUL:    begin p = xa * xb; return p[31:0]; end
      F3_MULH:   begin p = xa * xb; return p[63:32]; end
      F3_MULHSU: begin p = xa * $signed({32'd0, b}); return p[63:32]; end
      F3_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        qr = qa / qb;
        return qr;
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        qr = qa % qb;
        return qr;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drives one start pulse (called at a negedge) and watches until done.
  // lat = negedges after the start edge at which done was seen, -1 on timeout.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output int busy_n);
    funct3 = f3; srca = a; srcb = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_n = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0;
    srca = 32'd0; srcb = 32'd0; rd_in = 5'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++;
      $display("FAIL reset_result got %h want 0", result); end
    checks++;
    if (rd_out !== 5'd0) begin errors++;
      $display("FAIL reset_rd got %0d want 0", rd_out); end
    reset = 1'b0;
  endtask

  // Normal ops from fixed vectors: latency 34, busy for 33 cycles.
  task automatic test_fixed;
    logic [2:0]  f[7];
    logic [31:0] a[7], b[7], e[7];
    int lat, bn;
    wb_t x;
    f = '{F3_MUL, F3_MULHU, F3_MULH, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    a = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9,
          32'hFFFF_FFF9, 32'd100, 32'd100};
    b = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
          32'd2, 32'd7, 32'd7};
    e = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFD,
          32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{e[i], 5'(i + 1)});
      do_op(f[i], a[i], b[i], 5'(i + 1), lat, bn);
      x = sb.pop_front();
      checks++;
      if (lat != 34) begin errors++;
        $display("FAIL fixed%0d_latency got %0d want 34", i, lat); end
      checks++;
      if (bn != 33) begin errors++;
        $display("FAIL fixed%0d_busy_cycles got %0d want 33", i, bn); end
      checks++;
      if (result !== x.res) begin errors++;
        $display("FAIL fixed%0d_result got %h want %h", i, result, x.res); end
      checks++;
      if (rd_out !== x.rd) begin errors++;
        $display("FAIL fixed%0d_rd got %0d want %0d", i, rd_out, x.rd); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== x.res) begin errors++;
        $display("FAIL fixed%0d_hold done %b result %h want 0 %h",
                 i, done, result, x.res); end
    end
  endtask

  // Divide-by-zero and signed overflow finish one cycle after start.
  task automatic test_special;
    logic [2:0]  f[4];
    logic [31:0] a[4], b[4], e[4];
    int lat, bn;
    wb_t x;
    f = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{e[i], 5'(20 + i)});
      do_op(f[i], a[i], b[i], 5'(20 + i), lat, bn);
      x = sb.pop_front();
      checks++;
      if (lat != 1 || bn != 0) begin errors++;
        $display("FAIL spec%0d_timing lat %0d busy %0d want 1 0", i, lat, bn); end
      checks++;
      if (result !== x.res || rd_out !== x.rd) begin errors++;
        $display("FAIL spec%0d_wb got %h/%0d want %h/%0d",
                 i, result, rd_out, x.res, x.rd); end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] edges[5];
    int lat, bn, want_lat;
    wb_t x;
    edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      want_lat = (f[2] && (b == 32'd0 ||
                 ((f == F3_DIV || f == F3_REM) &&
                  a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      sb.push_back('{ref_mdu(f, a, b), 5'(i)});
      do_op(f, a, b, 5'(i), lat, bn);
      x = sb.pop_front();
      checks++;
      if (lat != want_lat) begin errors++;
        $display("FAIL rnd%0d_latency f3 %0d got %0d want %0d",
                 i, f, lat, want_lat); end
      checks++;
      if (result !== x.res || rd_out !== x.rd) begin errors++;
        $display("FAIL rnd%0d f3 %0d a %h b %h got %h/%0d want %h/%0d",
                 i, f, a, b, result, rd_out, x.res, x.rd); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    funct3 = F3_MULHU; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 funct3 = F3_DIV; srca = 32'd1000; srcb = 32'd3; rd_in = 5'd7;
    repeat (34) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || result !== 32'hFFFF_FFFE) begin errors++;
      $display("FAIL abort_pre busy %b result %h want 1 fffffffe", busy, result); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin errors++;
      $display("FAIL abort_state busy %b result %h rd %0d want 0 0 0",
               busy, result, rd_out); end
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", stray); end
  endtask

  task automatic test_back_to_back;
    int lat;
    wb_t x;
    sb.push_back('{32'd15, 5'd4});
    sb.push_back('{32'd14, 5'd9});
    funct3 = F3_MUL; srca = 32'd3; srcb = 32'd5; rd_in = 5'd4; start = 1'b1;
    @(posedge clk);
    #1 funct3 = F3_DIVU; srca = 32'd100; srcb = 32'd7; rd_in = 5'd9;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    x = sb.pop_front();
    checks++;
    if (lat != 34) begin errors++;
      $display("FAIL b2b_first_latency got %0d want 34", lat); end
    checks++;
    if (result !== x.res || rd_out !== x.rd) begin errors++;
      $display("FAIL b2b_first_wb got %h/%0d want %h/%0d",
               result, rd_out, x.res, x.rd); end
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    x = sb.pop_front();
    checks++;
    if (lat != 34) begin errors++;
      $display("FAIL b2b_second_latency got %0d want 34", lat); end
    checks++;
    if (result !== x.res || rd_out !== x.rd) begin errors++;
      $display("FAIL b2b_second_wb got %h/%0d want %h/%0d",
               result, rd_out, x.res, x.rd); end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_special;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit sitting between the register file read ports and its write port. It takes the two source operands read that cycle, performs any of the eight RV32M operations over multiple cycles, and presents a one-cycle write request (result, destination index, write enable) that drives the register file's third port. The core holds its PC and instruction while `busy` is high.

## Interface

- None. Datapath is fixed at 32 bits to match the register file.

- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a new operation; sampled in IDLE or DONE only
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `srca`  in  32  operand A (dividend / multiplicand), from `rd1`
- `srcb`  in  32  operand B (divisor / multiplier), from `rd2`
- `rd_in`  in  5  destination register index
- `busy`  out  1  high in CALC and FIX; core stalls
- `done`  out  1  one-cycle pulse; result valid; drives `we3`
- `result`  out  32  result; drives `wd3`; held until the next `done`
- `rd_out`  out  5  captured `rd_in`; drives `a3`

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + `start`: capture op, `rd_in`, operand magnitudes, and result signs. Then:
  - if a special case applies: load `result` directly and go to DONE;
  - otherwise clear iteration counter (5 bits) and go to CALC.
- `start` in CALC or FIX is ignored; no queueing.
- CALC: one iteration per cycle for 32 cycles, then FIX.
  - Multiply: unsigned shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, on magnitudes.
- FIX: apply sign correction and select the output word, register `result`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE (or start a new op if `start` is high).
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV, REM: both operands signed.
- Sign rules:
  - Negated 64-bit product when operand signs differ.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Output select: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
- Special cases (no CALC, `done` one cycle after the start edge):
  - divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = `srca`.
  - signed overflow, `srca`=0x80000000 and `srcb`=0xFFFFFFFF: DIV result = 0x80000000; REM result = 0.
- `rd_in`=0 is not special-cased here; the register file ignores writes to x0.

## Timing

- Reset values: state IDLE; `busy`, `done`, `result`, `rd_out` all 0; counter 0.
- Normal op: `start` sampled on edge k.
  - CALC iterations occur on edges k+1 to k+32.
  - FIX registers `result` on edge k+33.
  - `done` is high in the cycle after edge k+33, and `busy` drops in that same cycle.
- Special case: `done` is high in the cycle after edge k; `busy` is never asserted.
- Back-to-back: `start` high during DONE begins the next op on that edge, with no idle cycle.
- Reset mid-operation: abort on the next edge. No `done` for the aborted op; `result` returns to 0.
- `result` and `rd_out` change only on the edge that enters DONE (or on reset).

## Structure

- Shared package `riscv_pkg`: RV32M funct3 localparams and the MDU state enum.
- Single module. No sub-module is warranted; negation is inlined.

## Test plan

- MUL `srca`=7, `srcb`=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` at cycle 34, `busy` high for cycles 1–33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done` one cycle after start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- `reset` asserted 10 cycles into a DIV → next cycle `busy`=0 and `result`=0; no `done` pulse.
- `start` held high through DONE with a new op and `rd_in`=9 → second op starts with no gap, `rd_out`=9 at its `done`, and `start` during CALC is ignored.
